hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Pipeline sequencing block for the 5-stage core: detects RAW data hazards between ID and the EXE/MEM stages, resolves taken-branch flushes, and freezes the whole pipeline while a multi-cycle data memory access is outstanding.
- Drives hazard_detected into the decode controller, which squashes WB_EN, MEM_W_EN and EXE_CMD into a bubble.
- Drives freeze and flush controls to the PC and stage registers.
- Keeps a sticky memory-timeout error and a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_LEN, 5, register-file address width.
- FWD_EN, 1: 1 means a forwarding unit exists and only load-use stalls; 0 means stall on any RAW match in EXE or MEM.
- MEM_TIMEOUT, 16: maximum consecutive wait cycles before error; legal range 2..255.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_src1  in  REG_ADDR_LEN  ID source register 1.
- id_src2  in  REG_ADDR_LEN  ID source register 2.
- id_two_src  in  1  the ID instruction reads src2 (R-type, ST, BEQ).
- exe_dest  in  REG_ADDR_LEN  ID/EX destination register.
- exe_wb_en  in  1  ID/EX WB_EN.
- exe_mem_r_en  in  1  ID/EX MEM_R_EN (the instruction is a load).
- mem_dest  in  REG_ADDR_LEN  EX/MEM destination register.
- mem_wb_en  in  1  EX/MEM WB_EN.
- branch_taken  in  1  branch resolved taken in EXE.
- mem_req  in  1  the MEM stage performs a load or store this cycle.
- mem_ready  in  1  data-memory handshake: the access completes this cycle.
- hazard_detected  out  1  to the decode controller; inserts a bubble into ID/EX.
- pc_freeze  out  1  holds the PC.
- ifid_freeze  out  1  holds the IF/ID register.
- pipe_freeze  out  1  holds the PC and all stage registers (ID/EX, EX/MEM, MEM/WB included).
- ifid_flush  out  1  clears IF/ID to a NOP.
- idex_flush  out  1  clears ID/EX to a NOP.
- mem_timeout  out  1  sticky error flag.
- stall_count  out  CNT_W  saturating count of frozen cycles.

Behaviour:
- Reset (rst_n low, asynchronous): state = RUN, wait_cnt = 0, mem_timeout = 0, stall_count = 0. While rst_n is low all combinational outputs are forced to 0.
- States: RUN, MEM_WAIT, ERROR. State is encoded in 2 bits. wait_cnt is 8 bits.
- RUN:
  - If mem_req=1 and mem_ready=0: go to MEM_WAIT next cycle, wait_cnt <= 1.
  - Otherwise stay in RUN.
- MEM_WAIT:
  - If mem_ready=1: go to RUN, wait_cnt <= 0.
  - Else if wait_cnt == MEM_TIMEOUT-1: go to ERROR, mem_timeout <= 1.
  - Else wait_cnt <= wait_cnt+1.
- ERROR: stays in ERROR until reset.
- Memory freeze: mf = (state==RUN & mem_req & ~mem_ready) | (state==MEM_WAIT & ~mem_ready) | (state==ERROR).
  - mf is combinational, so the freeze is asserted in the first not-ready cycle.
  - It drops in the same cycle mem_ready rises.
- Data hazard:
  - m1 = id_src1 == D.
  - m2 = id_two_src & (id_src2 == D).
  - Register 0 never matches.
  - With FWD_EN=1: dh = id_valid & exe_wb_en & exe_mem_r_en & (exe_dest!=0) & (m1|m2), with D = exe_dest.
  - With FWD_EN=0: dh = id_valid & [ (exe_wb_en & exe_dest!=0 & match(exe_dest)) | (mem_wb_en & mem_dest!=0 & match(mem_dest)) ].
- Output priority (highest first):
  1. mf = 1:
     - pipe_freeze = pc_freeze = ifid_freeze = 1.
     - hazard_detected = 0, ifid_flush = 0, idex_flush = 0.
     - A branch_taken that arrives while frozen is held in EXE and acted on in the first unfrozen cycle.
  2. branch_taken = 1:
     - ifid_flush = idex_flush = 1.
     - hazard_detected = 0 and no freeze, because the instruction in ID is being discarded.
  3. dh = 1:
     - hazard_detected = pc_freeze = ifid_freeze = 1.
     - pipe_freeze = 0; the bubble enters ID/EX via the controller.
  4. Otherwise all control outputs are 0.
- Latency: all control outputs are combinational from the inputs and the current state, with zero cycles of latency. Only state, wait_cnt, mem_timeout and stall_count are registered.
- stall_count: increments on each clock edge where pc_freeze was 1. It saturates at all-ones and does not wrap.
- Load-use with FWD_EN=1 stalls exactly 1 cycle; the next cycle the load is in MEM and no longer matches.
- Simultaneous mem wait and load-use: only the freeze is applied; the hazard is re-evaluated after the freeze lifts.
- If reset is asserted mid-wait, the block returns immediately to RUN with the counters cleared.

Test Plan:
- Load-use, FWD_EN=1: exe_mem_r_en=1, exe_wb_en=1, exe_dest=5, id_src1=5, id_valid=1 → hazard_detected, pc_freeze and ifid_freeze are 1 for exactly that cycle, and stall_count goes 0→1.
- Register-0 and src2 gating: exe_dest=0, or id_src2 match with id_two_src=0 → no hazard. The same test with FWD_EN=0 and mem_dest=7=id_src2, id_two_src=1 → hazard_detected=1.
- Branch priority: branch_taken=1 together with a load-use match → ifid_flush=idex_flush=1, hazard_detected=0, pc_freeze=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → pipe_freeze=1 for 3 cycles, 0 in the ready cycle, state back to RUN, stall_count=3.
- Timeout, MEM_TIMEOUT=4: mem_ready held at 0 → mem_timeout=1 after the 4th wait cycle, pipe_freeze stays 1 permanently. Pulsing rst_n low then clears mem_timeout, stall_count and the freeze asynchronously.
- Saturation, CNT_W=4: 20 frozen cycles → stall_count=15 and holds.

Source files
------------

// File: rtl/hazard_stall_if.sv
// Control bundle between the 5-stage pipeline and the hazard/stall sequencing unit.
// The pipeline side is the master; the hazard unit is the slave.
interface hazard_stall_if #(
    parameter int unsigned REG_ADDR_LEN = 5,
    parameter int unsigned CNT_W        = 16
);
    logic                    id_valid;
    logic [REG_ADDR_LEN-1:0] id_src1;
    logic [REG_ADDR_LEN-1:0] id_src2;
    logic                    id_two_src;
    logic [REG_ADDR_LEN-1:0] exe_dest;
    logic                    exe_wb_en;
    logic                    exe_mem_r_en;
    logic [REG_ADDR_LEN-1:0] mem_dest;
    logic                    mem_wb_en;
    logic                    branch_taken;
    logic                    mem_req;
    logic                    mem_ready;

    logic                    hazard_detected;
    logic                    pc_freeze;
    logic                    ifid_freeze;
    logic                    pipe_freeze;
    logic                    ifid_flush;
    logic                    idex_flush;
    logic                    mem_timeout;
    logic [CNT_W-1:0]        stall_count;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src,
        output exe_dest, exe_wb_en, exe_mem_r_en,
        output mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
        input  hazard_detected, pc_freeze, ifid_freeze, pipe_freeze,
        input  ifid_flush, idex_flush, mem_timeout, stall_count
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src,
        input  exe_dest, exe_wb_en, exe_mem_r_en,
        input  mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
        output hazard_detected, pc_freeze, ifid_freeze, pipe_freeze,
        output ifid_flush, idex_flush, mem_timeout, stall_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// RAW hazard detection, branch flush and memory-wait freeze sequencing for the 5-stage core.
// Control outputs are combinational; only the wait FSM and the error/perf counters are registered.
module hazard_stall_unit #(
    parameter int unsigned REG_ADDR_LEN = 5,
    parameter bit          FWD_EN       = 1'b1,
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_stall_if.slave  hs
);
    localparam int unsigned WAIT_W    = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic mf, dh, m_exe, m_mem;
    logic haz_c, pc_frz_c, ifid_frz_c, pipe_frz_c, ifid_fl_c, idex_fl_c;

    // Source/destination match; register 0 is hardwired and never creates a dependency
    assign m_exe = (hs.exe_dest != '0) &&
                   ((hs.id_src1 == hs.exe_dest) || (hs.id_two_src && (hs.id_src2 == hs.exe_dest)));
    assign m_mem = (hs.mem_dest != '0) &&
                   ((hs.id_src1 == hs.mem_dest) || (hs.id_two_src && (hs.id_src2 == hs.mem_dest)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        mf          = 1'b0;
        dh          = 1'b0;
        haz_c       = 1'b0;
        pc_frz_c    = 1'b0;
        ifid_frz_c  = 1'b0;
        pipe_frz_c  = 1'b0;
        ifid_fl_c   = 1'b0;
        idex_fl_c   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                mf = hs.mem_req && !hs.mem_ready;
                if (mf) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                mf = !hs.mem_ready;
                if (hs.mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = ST_ERROR;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ERROR: mf = 1'b1;
            default:  state_d = ST_RUN;
        endcase

        // With forwarding only a load in EXE cannot be bypassed to ID
        if (FWD_EN) begin
            dh = hs.id_valid && hs.exe_wb_en && hs.exe_mem_r_en && m_exe;
        end else begin
            dh = hs.id_valid && ((hs.exe_wb_en && m_exe) || (hs.mem_wb_en && m_mem));
        end

        // Freeze beats flush beats bubble; a branch seen while frozen is held in EXE
        if (rst_n) begin
            if (mf) begin
                pipe_frz_c = 1'b1;
                pc_frz_c   = 1'b1;
                ifid_frz_c = 1'b1;
            end else if (hs.branch_taken) begin
                ifid_fl_c  = 1'b1;
                idex_fl_c  = 1'b1;
            end else if (dh) begin
                haz_c      = 1'b1;
                pc_frz_c   = 1'b1;
                ifid_frz_c = 1'b1;
            end
        end

        if (pc_frz_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign hs.hazard_detected = haz_c;
    assign hs.pc_freeze       = pc_frz_c;
    assign hs.ifid_freeze     = ifid_frz_c;
    assign hs.pipe_freeze     = pipe_frz_c;
    assign hs.ifid_flush      = ifid_fl_c;
    assign hs.idex_flush      = idex_fl_c;
    assign hs.mem_timeout     = timeout_q;
    assign hs.stall_count     = stall_cnt_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: two configurations of the hazard unit share one stimulus stream and are
// checked against a cycle-level reference model of the pipeline sequencing rules.
module tb_hazard_stall_unit;
    localparam int unsigned RA = 5;
    localparam int unsigned TO_A = 4;
    localparam int unsigned TO_B = 16;
    localparam int CMAX_A = 15;
    localparam int CMAX_B = 65535;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_stall_if #(.REG_ADDR_LEN(RA), .CNT_W(4))  ifa ();
    hazard_stall_if #(.REG_ADDR_LEN(RA), .CNT_W(16)) ifb ();

    hazard_stall_unit #(.REG_ADDR_LEN(RA), .FWD_EN(1'b1), .MEM_TIMEOUT(TO_A), .CNT_W(4))
        dut_a (.clk(clk), .rst_n(rst_n), .hs(ifa));
    hazard_stall_unit #(.REG_ADDR_LEN(RA), .FWD_EN(1'b0), .MEM_TIMEOUT(TO_B), .CNT_W(16))
        dut_b (.clk(clk), .rst_n(rst_n), .hs(ifb));

    typedef struct {
        logic          valid;
        logic [RA-1:0] s1, s2;
        logic          two;
        logic [RA-1:0] ed;
        logic          ewb, er;
        logic [RA-1:0] md;
        logic          mwb, br, mreq, mrdy;
    } stim_t;

    // ctl = {hazard_detected, pc_freeze, ifid_freeze, pipe_freeze, ifid_flush, idex_flush}
    typedef struct {
        string       tag;
        logic [5:0]  ctl_a, ctl_b;
        logic        to_a, to_b;
        logic [15:0] cnt_a, cnt_b;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: consecutive unserviced memory cycles, error latch, frozen-cycle count
    int waits_a, waits_b, cnt_a, cnt_b;
    bit err_a, err_b;

    function automatic bit dep(input stim_t s, input logic [RA-1:0] d);
        return (d != 0) && ((s.s1 == d) || (s.two && (s.s2 == d)));
    endfunction

    function automatic logic [5:0] ctl_of(input bit frz, input bit br, input bit haz);
        if (frz)      return 6'b011100;
        else if (br)  return 6'b000011;
        else if (haz) return 6'b111000;
        return 6'b000000;
    endfunction

    task automatic drive(input stim_t s);
        ifa.id_valid = s.valid;   ifb.id_valid = s.valid;
        ifa.id_src1 = s.s1;       ifb.id_src1 = s.s1;
        ifa.id_src2 = s.s2;       ifb.id_src2 = s.s2;
        ifa.id_two_src = s.two;   ifb.id_two_src = s.two;
        ifa.exe_dest = s.ed;      ifb.exe_dest = s.ed;
        ifa.exe_wb_en = s.ewb;    ifb.exe_wb_en = s.ewb;
        ifa.exe_mem_r_en = s.er;  ifb.exe_mem_r_en = s.er;
        ifa.mem_dest = s.md;      ifb.mem_dest = s.md;
        ifa.mem_wb_en = s.mwb;    ifb.mem_wb_en = s.mwb;
        ifa.branch_taken = s.br;  ifb.branch_taken = s.br;
        ifa.mem_req = s.mreq;     ifb.mem_req = s.mreq;
        ifa.mem_ready = s.mrdy;   ifb.mem_ready = s.mrdy;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{valid:0, s1:0, s2:0, two:0, ed:0, ewb:0, er:0, md:0, mwb:0, br:0, mreq:0, mrdy:1};
        return s;
    endfunction

    // One pipeline cycle: drive, predict, push, let the clock edge happen, advance the model
    task automatic cycle(input stim_t s, input string tag);
        exp_t e;
        bit frz_a, frz_b, haz_a, haz_b, pc_a, pc_b;
        drive(s);
        frz_a = err_a || (!s.mrdy && (s.mreq || waits_a > 0));
        frz_b = err_b || (!s.mrdy && (s.mreq || waits_b > 0));
        haz_a = s.valid && s.ewb && s.er && dep(s, s.ed);
        haz_b = s.valid && ((s.ewb && dep(s, s.ed)) || (s.mwb && dep(s, s.md)));
        e.tag   = tag;
        e.ctl_a = ctl_of(frz_a, s.br, haz_a);
        e.ctl_b = ctl_of(frz_b, s.br, haz_b);
        e.to_a  = err_a;
        e.to_b  = err_b;
        e.cnt_a = 16'(cnt_a);
        e.cnt_b = 16'(cnt_b);
        sb.push_back(e);
        pc_a = e.ctl_a[4];
        pc_b = e.ctl_b[4];
        @(posedge clk);
        #1;
        if (!err_a) begin
            if (frz_a) begin waits_a++; if (waits_a >= TO_A) err_a = 1; end
            else waits_a = 0;
        end
        if (!err_b) begin
            if (frz_b) begin waits_b++; if (waits_b >= TO_B) err_b = 1; end
            else waits_b = 0;
        end
        if (pc_a && cnt_a < CMAX_A) cnt_a++;
        if (pc_b && cnt_b < CMAX_B) cnt_b++;
    endtask

    // Asynchronous reset pulse; busy inputs show that outputs are forced low meanwhile
    task automatic reset_pulse(input string tag);
        exp_t  e;
        stim_t s;
        rst_n = 1'b0;
        waits_a = 0; waits_b = 0; cnt_a = 0; cnt_b = 0; err_a = 0; err_b = 0;
        s = '{valid:1, s1:5, s2:5, two:1, ed:5, ewb:1, er:1, md:5, mwb:1, br:1, mreq:1, mrdy:0};
        drive(s);
        e = '{tag:tag, ctl_a:6'b0, ctl_b:6'b0, to_a:1'b0, to_b:1'b0, cnt_a:16'd0, cnt_b:16'd0};
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input string tag, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%s] @%0t: got 0x%0h expected 0x%0h", name, tag, $time, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a settled response, pop and compare it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ctl_a", e.tag, 16'({ifa.hazard_detected, ifa.pc_freeze, ifa.ifid_freeze,
                      ifa.pipe_freeze, ifa.ifid_flush, ifa.idex_flush}), 16'(e.ctl_a));
                check("ctl_b", e.tag, 16'({ifb.hazard_detected, ifb.pc_freeze, ifb.ifid_freeze,
                      ifb.pipe_freeze, ifb.ifid_flush, ifb.idex_flush}), 16'(e.ctl_b));
                check("timeout_a", e.tag, 16'(ifa.mem_timeout), 16'(e.to_a));
                check("timeout_b", e.tag, 16'(ifb.mem_timeout), 16'(e.to_b));
                check("count_a", e.tag, 16'(ifa.stall_count), e.cnt_a);
                check("count_b", e.tag, ifb.stall_count, e.cnt_b);
            end
        end
    end

    initial begin
        stim_t s;
        int    guard;
        rst_n = 1'b0;
        drive(idle());
        @(posedge clk);
        #1;
        reset_pulse("reset");

        // Load-use, then the load advances to MEM
        s = idle(); s.valid = 1; s.s1 = 5; s.ed = 5; s.ewb = 1; s.er = 1;
        cycle(s, "load_use");
        s = idle(); s.valid = 1; s.s1 = 5; s.md = 5; s.mwb = 1;
        cycle(s, "load_in_mem");
        cycle(idle(), "after_load_use");

        // Register 0 and src2 gating
        s = idle(); s.valid = 1; s.s1 = 0; s.ed = 0; s.ewb = 1; s.er = 1;
        cycle(s, "reg0");
        s = idle(); s.valid = 1; s.s1 = 3; s.s2 = 7; s.two = 0; s.ed = 7; s.ewb = 1; s.er = 1;
        s.md = 7; s.mwb = 1;
        cycle(s, "src2_unused");
        s = idle(); s.valid = 1; s.s1 = 3; s.s2 = 7; s.two = 1; s.md = 7; s.mwb = 1;
        cycle(s, "src2_mem_match");
        s.valid = 0;
        cycle(s, "id_invalid");

        // Branch beats load-use
        s = idle(); s.valid = 1; s.s1 = 5; s.ed = 5; s.ewb = 1; s.er = 1; s.br = 1;
        cycle(s, "branch_prio");

        // Memory wait of 3 cycles with a held branch
        reset_pulse("reset_mw");
        s = idle(); s.mreq = 1; s.mrdy = 0; s.br = 1; s.valid = 1; s.s1 = 5; s.ed = 5;
        s.ewb = 1; s.er = 1;
        for (int i = 0; i < 3; i++) cycle(s, "mem_wait");
        s.mrdy = 1;
        cycle(s, "mem_ready");
        cycle(idle(), "mem_done");

        // Timeout and saturation, then an asynchronous reset out of the error state
        s = idle(); s.mreq = 1; s.mrdy = 0;
        for (int i = 0; i < 20; i++) cycle(s, "timeout_sat");
        cycle(idle(), "error_hold");
        reset_pulse("reset_err");
        cycle(idle(), "after_err");

        // Randomized traffic with periodic resets
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 59) reset_pulse("rand_reset");
            s.valid = ($urandom_range(0, 3) != 0);
            s.s1    = RA'($urandom_range(0, 7));
            s.s2    = RA'($urandom_range(0, 7));
            s.two   = 1'($urandom_range(0, 1));
            s.ed    = RA'($urandom_range(0, 7));
            s.ewb   = 1'($urandom_range(0, 1));
            s.er    = 1'($urandom_range(0, 1));
            s.md    = RA'($urandom_range(0, 7));
            s.mwb   = 1'($urandom_range(0, 1));
            s.br    = ($urandom_range(0, 7) == 0);
            s.mreq  = ($urandom_range(0, 3) == 0);
            s.mrdy  = ($urandom_range(0, 2) != 0);
            cycle(s, "random");
        end

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
